// File: rtl/bus_rr_sched.sv
// Round-robin scheduler for a shared packet bus: arbitrates between driver FIFOs,
// pops the granted head packet and pushes it to its destination port(s).
module bus_rr_sched #(
  parameter int drvrs = 4,
  parameter int pckg_sz = 16,
  parameter int id_w = 8,
  parameter logic [id_w-1:0] broadcast = {id_w{1'b1}}
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [drvrs-1:0]            pndng,
  input  logic [drvrs*pckg_sz-1:0]    D_pop,
  output logic [drvrs-1:0]            pop,
  output logic [drvrs-1:0]            push,
  output logic [pckg_sz-1:0]          D_push,
  output logic                        busy,
  output logic [$clog2(drvrs)-1:0]    grant_id,
  output logic [15:0]                 pkt_cnt,
  output logic [15:0]                 drop_cnt
);

  localparam int gw = $clog2(drvrs);

  // Handshake: pndng[i] high means FIFO i presents a valid head on its D_pop slice;
  // pop[i] is a single-cycle strobe consuming that head. push is a strobe mask with
  // D_push valid in the same cycle; receivers have no back-pressure.
  typedef enum logic [1:0] {IDLE, POP, PUSH, DROP} state_t;

  state_t               state, next_state;
  logic [gw-1:0]        last_grant, last_grant_d;
  logic [pckg_sz-1:0]   data_q, data_d;
  logic [gw-1:0]        pick, grant_d;
  logic                 pick_ok;
  logic [id_w-1:0]      dest;
  logic [drvrs-1:0]     mask;
  logic                 mask_ok;
  logic [drvrs-1:0]     pop_d, push_d;
  logic [pckg_sz-1:0]   d_push_d;
  logic [15:0]          pkt_cnt_d, drop_cnt_d;

  assign busy = (state != IDLE);
  assign dest = data_q[pckg_sz-1 -: id_w];

  // First pending requester after the last one served, wrapping around.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = 1; k <= drvrs; k++) begin
      if (!pick_ok && pndng[(int'(last_grant) + k) % drvrs]) begin
        pick    = gw'((int'(last_grant) + k) % drvrs);
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    mask    = '0;
    mask_ok = 1'b0;
    if (dest == broadcast) begin
      mask    = ~(drvrs'(1) << grant_id);
      mask_ok = 1'b1;
    end else if (int'(dest) < drvrs && int'(dest) != int'(grant_id)) begin
      mask    = drvrs'(1) << dest;
      mask_ok = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_ok) next_state = POP;
      POP:     next_state = mask_ok ? PUSH : DROP;
      PUSH:    next_state = IDLE;
      DROP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes land in the cycle after the decision.
  always_comb begin
    pop_d        = '0;
    push_d       = '0;
    d_push_d     = D_push;
    pkt_cnt_d    = pkt_cnt;
    drop_cnt_d   = drop_cnt;
    grant_d      = grant_id;
    data_d       = data_q;
    last_grant_d = last_grant;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          grant_d     = pick;
          data_d      = D_pop[int'(pick)*pckg_sz +: pckg_sz];
          pop_d[pick] = 1'b1;
        end
      end
      POP: begin
        last_grant_d = grant_id;
        if (mask_ok) begin
          push_d    = mask;
          d_push_d  = data_q;
          pkt_cnt_d = (pkt_cnt == 16'hFFFF) ? pkt_cnt : pkt_cnt + 16'd1;
        end else begin
          drop_cnt_d = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop        <= '0;
      push       <= '0;
      D_push     <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      grant_id   <= '0;
      data_q     <= '0;
      last_grant <= gw'(drvrs - 1);
    end else begin
      pop        <= pop_d;
      push       <= push_d;
      D_push     <= d_push_d;
      pkt_cnt    <= pkt_cnt_d;
      drop_cnt   <= drop_cnt_d;
      grant_id   <= grant_d;
      data_q     <= data_d;
      last_grant <= last_grant_d;
    end
  end

endmodule

// File: doc/bus_rr_sched.md
Name: bus_rr_sched

Overview:
- Round-robin scheduler for the shared packet bus between `drvrs` driver FIFOs.
- Each cycle it watches every FIFO's `pndng` and grants the bus to one requester, fairly, by rotating priority.
- It pops that FIFO's head packet, decodes the destination ID and pushes the packet to the destination port or ports. Broadcast goes to every port except the source.
- It sits between the per-driver FIFO interfaces (`pndng`/`pop`/`D_pop`) and the per-port receive interfaces (`push`/`D_push`), in place of a fixed-priority bus core.

Parameters:
- `drvrs`, 4, number of bus ports (2..16).
- `pckg_sz`, 16, packet width in bits; must be at least 9.
- `id_w`, 8, width of the destination-ID field held in `packet[pckg_sz-1 -: id_w]`.
- `broadcast`, {id_w{1'b1}}, destination ID that means "all ports except source".

Ports:
- `clk`, in, 1, single clock; everything updates on the rising edge.
- `reset`, in, 1, asynchronous reset, active low; all state clears immediately while low.
- `pndng`, in, `drvrs`, bit i high means FIFO i is non-empty and its head is presented on `D_pop` slice i.
- `D_pop`, in, `drvrs*pckg_sz`, flattened FIFO head data; slice i is bits `[i*pckg_sz +: pckg_sz]`.
- `pop`, out, `drvrs`, one-hot one-cycle pop strobe to the granted FIFO.
- `push`, out, `drvrs`, push strobe mask to the destination ports.
- `D_push`, out, `pckg_sz`, packet data shared by all ports; valid when any `push` bit is high.
- `busy`, out, 1, high in any state other than IDLE.
- `grant_id`, out, `$clog2(drvrs)`, index of the current or last granted source.
- `pkt_cnt`, out, 16, count of delivered packets; saturates at 16'hFFFF.
- `drop_cnt`, out, 16, count of dropped packets; saturates at 16'hFFFF.

Behaviour:
- Reset values:
  - `pop`, `push`, `D_push`, `busy`, `pkt_cnt`, `drop_cnt` all 0.
  - `grant_id` = 0.
  - Internal `last_grant` = `drvrs-1`, so the first arbitration favours port 0.
  - FSM in IDLE.
- All outputs are registered.
- FSM states: IDLE, POP, PUSH, DROP.
- IDLE:
  - If `pndng` is 0, stay in IDLE.
  - Otherwise pick the first set bit of `pndng` scanning upward from `last_grant+1` modulo `drvrs`.
  - Latch the chosen index into `grant_id`, latch `D_pop` slice `grant_id` into `data_q`, then go to POP.
- POP, exactly one cycle:
  - `pop[grant_id]` = 1; all other `pop` bits 0.
  - Decode `dest = data_q[pckg_sz-1 -: id_w]`:
    - `dest == broadcast`: mask = all ones except bit `grant_id`.
    - `dest < drvrs` and `dest != grant_id`: mask = one-hot at `dest`.
    - Otherwise (out of range, or self-addressed): invalid.
  - Go to PUSH if the mask is valid, else DROP.
- PUSH, exactly one cycle:
  - `push` = mask and `D_push` = `data_q`.
  - `pkt_cnt` += 1, saturating.
  - `last_grant` <= `grant_id`; go to IDLE.
- DROP, exactly one cycle:
  - `push` = 0, `drop_cnt` += 1, saturating.
  - `last_grant` <= `grant_id`; go to IDLE.
- Timing: IDLE-sample to `pop` edge is 1 cycle; `pop` to `push` is 1 cycle. Maximum throughput is one packet per 3 cycles (IDLE→POP→PUSH→IDLE).
- `D_push` holds its value after PUSH until the next PUSH. Receivers sample it only when `push` is high.
- `pndng` is sampled only in IDLE. A FIFO that asserts or deasserts `pndng` during POP/PUSH/DROP is not seen until the next IDLE.
- A granted source is never re-granted until every other pending source has been served once, which bounds starvation to `drvrs-1` packets.
- With `drvrs` = 2, broadcast from port 0 delivers to port 1 only.
- Reset asserted mid-transfer:
  - `pop`/`push` drop to 0 immediately and the FSM returns to IDLE.
  - The in-flight packet is lost if already popped, and no counter increments for it.
- `pkt_cnt` and `drop_cnt` stick at 16'hFFFF; they do not wrap.

Test Plan:
- Single request, default parameters:
  - Stimulus: `pndng`=4'b0100, port 2 head = 16'h01AB.
  - Required: `pop`=4'b0100 for 1 cycle, next cycle `push`=4'b0010 with `D_push`=16'h01AB, `pkt_cnt`=1, `grant_id`=2.
- Round-robin fairness:
  - Stimulus: `pndng` held at 4'b1111, each FIFO holding 2 valid packets.
  - Required: grant order is 0,1,2,3,0,1,2,3, one `pop` every 3 cycles, `pkt_cnt`=8.
- Broadcast:
  - Stimulus: port 1 head = 16'hFF5A.
  - Required: `push`=4'b1101, `D_push`=16'hFF5A, `pkt_cnt`+=1.
- Drops:
  - Stimulus: port 0 head dest 8'h07 (out of range), then port 3 head dest 8'h03 (self).
  - Required: no `push` for either, `drop_cnt`=2, `pkt_cnt` unchanged; `pop` still fires for each.
- Reset mid-transfer:
  - Stimulus: drive `reset` low during POP.
  - Required: `pop`, `push`, `busy`, both counters read 0 asynchronously. After release with port 0 pending, the first grant goes to port 0.
- Counter saturation:
  - Stimulus: force `pkt_cnt` to 16'hFFFE, then deliver 3 packets.
  - Required: `pkt_cnt` reads 16'hFFFF and stays at 16'hFFFF.
